pipe_hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage core (IF, ID, EXE, MEM, WB).
- Decides every cycle whether to:
  - freeze the PC and IF/ID register,
  - inject a bubble into the ID/EX register (drives its flush input),
  - flush IF/ID on a taken branch,
  - freeze the whole pipe while a multi-cycle memory access is outstanding.
- Keeps saturating stall and wait statistics and a sticky memory-timeout flag.

---
 rtl/pipe_hazard_ctrl_if.sv | 54 +++++
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline and pipe_hazard_ctrl.
// The pipeline side uses the master modport and the controller uses slave.
//
// Memory handshake: mem_req is raised by MEM when it starts an access and is
// held until completion. mem_ready high in a cycle means the access finishes
// in that cycle. If mem_req and mem_ready are both high in the first cycle,
// the access completes in a single cycle and causes no freeze. mem_ready is
// only meaningful while mem_req is high or an access is outstanding.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // ID stage operands
  logic             id_valid;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  // EXE and MEM producers
  logic [3:0]       ex_dest;
  logic             ex_wb_en;
  logic             ex_mem_r_en;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  // Branch and memory events
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             stat_clr;
  // Pipeline controls
  logic             freeze_pc;
  logic             flush_if_id;
  logic             bubble_id_ex;
  logic             freeze_all;
  // Status, statistics and debug
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       state_dbg;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src,
    output ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en,
    output branch_taken, mem_req, mem_ready, stat_clr,
    input  freeze_pc, flush_if_id, bubble_id_ex, freeze_all,
    input  mem_err, stall_cnt, wait_cnt, state_dbg
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src,
    input  ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en,
    input  branch_taken, mem_req, mem_ready, stat_clr,
    output freeze_pc, flush_if_id, bubble_id_ex, freeze_all,
    output mem_err, stall_cnt, wait_cnt, state_dbg
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Decides freeze / bubble / flush each cycle, freezes the whole pipe during
// multi-cycle memory accesses with a WAIT_MAX timeout abort, and keeps
// saturating stall / wait statistics plus a sticky memory-error flag.
// Optional feature macro: PIPE_FORWARDING_EN (load-use-only hazard check).
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_t;

  localparam logic [15:0]      WAIT_MAX_L = 16'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic hz_ex;
  logic hazard;
  logic abort;
  logic freeze_pc_raw, flush_raw, bubble_raw, freeze_all_raw;
  logic freeze_pc, flush_if_id, bubble_id_ex, freeze_all;

  // RAW dependency of the ID instruction on the EXE producer
  always_comb begin
    hz_ex = bus.ex_wb_en &
            ((bus.ex_dest == bus.id_src1) |
             (bus.id_two_src & (bus.ex_dest == bus.id_src2)));
  end

`ifdef PIPE_FORWARDING_EN
  // Forwarding covers everything except a load result still in EXE
  always_comb begin
    hazard = bus.id_valid & hz_ex & bus.ex_mem_r_en;
  end
`else
  logic hz_mem;

  // Without forwarding any pending write in EXE or MEM must be waited out
  always_comb begin
    hz_mem = bus.mem_wb_en &
             ((bus.mem_dest == bus.id_src1) |
              (bus.id_two_src & (bus.mem_dest == bus.id_src2)));
    hazard = bus.id_valid & (hz_ex | hz_mem);
  end
`endif

  // Control decode and next-state / timeout logic
  always_comb begin
    logic eval;
    eval           = 1'b0;
    abort          = 1'b0;
    freeze_pc_raw  = 1'b0;
    flush_raw      = 1'b0;
    bubble_raw     = 1'b0;
    freeze_all_raw = 1'b0;
    state_d        = state_q;
    tmo_d          = tmo_q;

    unique case (state_q)
      RUN: begin
        if (bus.mem_req & ~bus.mem_ready) begin
          // First cycle of a multi-cycle access counts as one wait cycle
          freeze_all_raw = 1'b1;
          state_d        = MEM_WAIT;
          tmo_d          = 16'd1;
        end else begin
          eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          eval    = 1'b1;
          state_d = RUN;
          tmo_d   = 16'd0;
        end else if (tmo_q == WAIT_MAX_L) begin
          // Give up: release the pipe this cycle and flag the error
          abort   = 1'b1;
          state_d = RUN;
          tmo_d   = 16'd0;
        end else begin
          freeze_all_raw = 1'b1;
          tmo_d          = tmo_q + 16'd1;
        end
      end
      default: begin
        state_d = RUN;
        tmo_d   = 16'd0;
      end
    endcase

    // Branch wins over hazard: the stalled ID instruction is discarded anyway
    if (eval) begin
      if (bus.branch_taken) begin
        flush_raw  = 1'b1;
        bubble_raw = 1'b1;
      end else if (hazard) begin
        freeze_pc_raw = 1'b1;
        bubble_raw    = 1'b1;
      end
    end
  end

  // Controls are held low for as long as reset is asserted
  always_comb begin
    freeze_pc    = freeze_pc_raw  & rst;
    flush_if_id  = flush_raw      & rst;
    bubble_id_ex = bubble_raw     & rst;
    freeze_all   = freeze_all_raw & rst;
  end

  // Saturating statistics and sticky error; clear beats increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q | abort;
    if (bus.stat_clr) begin
      stall_cnt_d = '0;
      wait_cnt_d  = '0;
      mem_err_d   = 1'b0;
    end else begin
      if (freeze_pc & ~freeze_all & (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (freeze_all & (wait_cnt_q != CNT_MAX)) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  // State, timeout and statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      tmo_q       <= 16'd0;
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Drive the bundle outputs
  always_comb begin
    bus.freeze_pc    = freeze_pc;
    bus.flush_if_id  = flush_if_id;
    bus.bubble_id_ex = bubble_id_ex;
    bus.freeze_all   = freeze_all;
    bus.mem_err      = mem_err_q;
    bus.stall_cnt    = stall_cnt_q;
    bus.wait_cnt     = wait_cnt_q;
    bus.state_dbg    = state_q;
  end

endmodule
